cache_fill_ctrl: RTL and testbench
==================================

// Module: cache_fill_ctrl
// PURPOSE
//  Multi-requester cache-line fill engine for the next-generation WISC core.
//  Arbitrates block misses from NUM_REQ caches (0 = D-cache, 1 = I-cache) onto the
//  single pipelined main memory. Streams WORDS_PER_BLOCK words into the winner's
//  data array, then writes its tag. Each requester stalls until its own fill_done.
// PARAMETERS
//  DWIDTH           16  data word width (bits)
//  AWIDTH           16  byte address width
//  WORDS_PER_BLOCK   8  words per cache line; power of 2, >= 2
//  NUM_REQ           2  number of requesting caches; index 0 = highest priority
// PORTS
//  clk            in   1                  clock; all state changes on rising edge
//  rst            in   1                  synchronous reset, active-high
//  req            in   NUM_REQ            per-cache miss request (level; held until that cache's done)
//  req_addr       in   NUM_REQ*AWIDTH     miss byte address; slice i = [i*AWIDTH +: AWIDTH]
//  mem_en         out  1                  memory read issue strobe (fills never write memory)
//  mem_addr       out  AWIDTH             memory read byte address
//  mem_data_valid in   1                  read data returning from memory this cycle
//  mem_data       in   DWIDTH             returned read data
//  grant          out  NUM_REQ            one-hot; the requester being filled
//  fill_we        out  1                  write fill_data into the data array
//  fill_idx       out  clog2(WPB)         word offset within the line being written
//  fill_data      out  DWIDTH             mem_data passed through on fill_we
//  tag_we         out  1                  write tag + valid for the line (last word only)
//  fill_done      out  NUM_REQ            one-cycle pulse to the finished requester
//  busy           out  1                  1 whenever state != IDLE
// BEHAVIOUR
//  Address handling
//   - Line base = req_addr & ~(2*WPB-1). Words are 2 bytes.
//   - Issue k uses mem_addr = base + 2*k. Arithmetic is mod 2^AWIDTH, so the top line wraps.
//  Memory model
//   - Pipelined, in-order, fixed latency L >= 1; accepts one read per cycle.
//   - The controller is L-agnostic. It counts returns on mem_data_valid, not cycles.
//  FSM: IDLE -> FILL -> IDLE
//   - IDLE: if |req, latch the lowest-index set req as the winner.
//     Latch its line base, set grant, move to FILL. Both counters clear.
//   - FILL, issue side: mem_en=1 while issue_cnt < WPB, one address per cycle.
//     Issue count is exactly WPB, then mem_en=0.
//   - FILL, return side: each mem_data_valid asserts fill_we combinationally,
//     with fill_idx = recv_cnt and fill_data = mem_data; recv_cnt increments.
//   - Last word (valid && recv_cnt == WPB-1): tag_we=1 and fill_done[winner]=1
//     in the same cycle; next state IDLE and grant clears.
//   - Re-arbitration happens in IDLE, so there is one idle cycle between back-to-back fills.
//  Latency
//   - req seen in IDLE at cycle 0; issues in cycles 1..WPB.
//   - Last data and done arrive at cycle WPB+L. Example: WPB=8, L=4 -> done at cycle 12.
//  Arbitration and boundaries
//   - Fixed priority, non-preemptive. A higher-priority req arriving mid-fill waits.
//   - req or req_addr changing mid-fill is ignored; the latched line completes.
//   - mem_data_valid while IDLE is ignored: no fill_we, counters unchanged.
//   - Simultaneous req on all inputs: index 0 wins; index 1 is served next, after one idle cycle.
//   - Counters are clog2(WPB)+1 bits wide; they never wrap within a fill.
//  Reset (rst=1 at an edge, including mid-fill)
//   - State goes to IDLE; counters and latched address clear.
//   - Every output is 0 on the following cycle: mem_en, mem_addr, grant, fill_we,
//     fill_idx, tag_we, fill_done, busy.
//   - Memory shares rst, so in-flight reads are discarded. The partial line is never tagged.
// TESTING
//  1 Single D miss: req=01, addr0=0x1236, L=4.
//    -> mem_addr 0x1230..0x123E in cycles 1-8; fill_we at cycles 5-12, idx 0..7;
//       tag_we and fill_done=01 at cycle 12.
//  2 Simultaneous: req=11, addr0=0x0040, addr1=0x8000.
//    -> D line filled first; idle cycle; grant=10; I line at 0x8000; fill_done=10 last.
//  3 Priority hold-off: I fill running, req[0] rises at cycle 3.
//    -> I fill completes untouched; D grant only in the IDLE cycle after done.
//  4 Wrap and latency sweep: addr=0xFFFE with L=1, then L=7.
//    -> base 0xFFF0, last issue 0xFFFE; exactly 8 fill_we each time; done at cycles 9 and 15.
//  5 Reset mid-fill: rst at cycle 6 of a fill.
//    -> all outputs 0 next cycle; no tag_we; a new req is served from word 0.
//  6 Stray valid: pulse mem_data_valid while IDLE.
//    -> no fill_we or tag_we; the next fill still writes idx 0..7 in order.

Source files
------------

// File: rtl/cache_fill_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : cache_fill_ctrl
//  Brief    : Fixed-priority cache-line fill engine streaming a block from a
//             pipelined main memory into the winning cache's data array.
//  Revision : 1.0
// ============================================================================
module cache_fill_ctrl #(
    parameter int DWIDTH          = 16,
    parameter int AWIDTH          = 16,
    parameter int WORDS_PER_BLOCK = 8,
    parameter int NUM_REQ         = 2
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NUM_REQ-1:0]                   req_i,
    input  logic [NUM_REQ*AWIDTH-1:0]            req_addr_i,
    output logic                                 mem_en_o,
    output logic [AWIDTH-1:0]                    mem_addr_o,
    input  logic                                 mem_data_valid_i,
    input  logic [DWIDTH-1:0]                    mem_data_i,
    output logic [NUM_REQ-1:0]                   grant_o,
    output logic                                 fill_we_o,
    output logic [$clog2(WORDS_PER_BLOCK)-1:0]   fill_idx_o,
    output logic [DWIDTH-1:0]                    fill_data_o,
    output logic                                 tag_we_o,
    output logic [NUM_REQ-1:0]                   fill_done_o,
    output logic                                 busy_o
);

    localparam int IDXW = $clog2(WORDS_PER_BLOCK);
    localparam int CNTW = IDXW + 1;
    localparam logic [AWIDTH-1:0] LINE_MASK = ~AWIDTH'(2 * WORDS_PER_BLOCK - 1);
    localparam logic [CNTW-1:0]   WPB_CNT   = CNTW'(WORDS_PER_BLOCK);
    localparam logic [CNTW-1:0]   LAST_CNT  = CNTW'(WORDS_PER_BLOCK - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

    state_t              state_q;
    logic [NUM_REQ-1:0]  grant_q;
    logic [AWIDTH-1:0]   base_q;
    logic [CNTW-1:0]     issue_cnt_q;
    logic [CNTW-1:0]     recv_cnt_q;

    logic [NUM_REQ-1:0]  sel_gnt;
    logic [AWIDTH-1:0]   sel_addr;
    logic                issue;
    logic                last_word;

    // Scan from the top so the lowest set index is the final assignment.
    always_comb begin
        sel_gnt  = '0;
        sel_addr = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                sel_gnt    = '0;
                sel_gnt[i] = 1'b1;
                sel_addr   = req_addr_i[i*AWIDTH +: AWIDTH];
            end
        end
    end

    assign issue     = (state_q == FILL) && (issue_cnt_q < WPB_CNT);
    assign fill_we_o = (state_q == FILL) && mem_data_valid_i;
    assign last_word = fill_we_o && (recv_cnt_q == LAST_CNT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            base_q      <= '0;
            issue_cnt_q <= '0;
            recv_cnt_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (|req_i) begin
                        state_q     <= FILL;
                        grant_q     <= sel_gnt;
                        base_q      <= sel_addr & LINE_MASK;
                        issue_cnt_q <= '0;
                        recv_cnt_q  <= '0;
                    end
                end
                FILL: begin
                    if (issue) begin
                        issue_cnt_q <= issue_cnt_q + 1'b1;
                    end
                    if (last_word) begin
                        state_q     <= IDLE;
                        grant_q     <= '0;
                        issue_cnt_q <= '0;
                        recv_cnt_q  <= '0;
                    end else if (fill_we_o) begin
                        recv_cnt_q  <= recv_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    grant_q <= '0;
                end
            endcase
        end
    end

    // Address and index are gated so idle cycles present all-zero buses.
    assign mem_en_o    = issue;
    assign mem_addr_o  = issue ? (base_q + AWIDTH'({issue_cnt_q, 1'b0})) : '0;
    assign fill_idx_o  = fill_we_o ? recv_cnt_q[IDXW-1:0] : '0;
    assign fill_data_o = fill_we_o ? mem_data_i : '0;
    assign tag_we_o    = last_word;
    assign fill_done_o = last_word ? grant_q : '0;
    assign grant_o     = grant_q;
    assign busy_o      = (state_q == FILL);

endmodule
`default_nettype wire

// File: tb/tb_cache_fill_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cache_fill_ctrl
//  Brief    : Directed self-checking bench for cache_fill_ctrl with a
//             variable-latency pipelined memory model.
//  Revision : 1.0
// ============================================================================
module tb_cache_fill_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req;
    logic [31:0] req_addr;
    logic        mem_en;
    logic [15:0] mem_addr;
    logic        mem_data_valid;
    logic [15:0] mem_data;
    logic [1:0]  grant;
    logic        fill_we;
    logic [2:0]  fill_idx;
    logic [15:0] fill_data;
    logic        tag_we;
    logic [1:0]  fill_done;
    logic        busy;

    int          lat;
    logic        stray;
    logic        pv [8];
    logic [15:0] pd [8];
    int          errors = 0;
    int          checks = 0;

    cache_fill_ctrl #(
        .DWIDTH(16), .AWIDTH(16), .WORDS_PER_BLOCK(8), .NUM_REQ(2)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .req_i            (req),
        .req_addr_i       (req_addr),
        .mem_en_o         (mem_en),
        .mem_addr_o       (mem_addr),
        .mem_data_valid_i (mem_data_valid),
        .mem_data_i       (mem_data),
        .grant_o          (grant),
        .fill_we_o        (fill_we),
        .fill_idx_o       (fill_idx),
        .fill_data_o      (fill_data),
        .tag_we_o         (tag_we),
        .fill_done_o      (fill_done),
        .busy_o           (busy)
    );

    always #5 clk = ~clk;

    // Memory: in-order pipe, data = address ^ A5A5, returned lat cycles later.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                pv[i] <= 1'b0;
                pd[i] <= '0;
            end
        end else begin
            pv[0] <= mem_en;
            pd[0] <= mem_addr ^ 16'hA5A5;
            for (int i = 1; i < 8; i++) begin
                pv[i] <= pv[i-1];
                pd[i] <= pd[i-1];
            end
        end
    end

    assign mem_data_valid = pv[lat-1] | stray;
    assign mem_data       = pd[lat-1];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle_chk(input string nm);
        chk({nm, " busy"},   32'(busy),   32'd0);
        chk({nm, " grant"},  32'(grant),  32'd0);
        chk({nm, " mem_en"}, 32'(mem_en), 32'd0);
    endtask

    task automatic all_zero_chk(input string nm);
        chk({nm, " mem_en"},    32'(mem_en),    32'd0);
        chk({nm, " mem_addr"},  32'(mem_addr),  32'd0);
        chk({nm, " grant"},     32'(grant),     32'd0);
        chk({nm, " fill_we"},   32'(fill_we),   32'd0);
        chk({nm, " fill_idx"},  32'(fill_idx),  32'd0);
        chk({nm, " tag_we"},    32'(tag_we),    32'd0);
        chk({nm, " fill_done"}, 32'(fill_done), 32'd0);
        chk({nm, " busy"},      32'(busy),      32'd0);
    endtask

    // Called one cycle before the arbitration edge; cycle 1 is the first issue.
    task automatic run_fill(input string nm, input logic [1:0] g, input logic [15:0] base,
                            input int done_at, input int raise0_at);
        int iss  = 0;
        int wr   = 0;
        bit done = 1'b0;
        for (int c = 1; c <= 40 && !done; c++) begin
            @(negedge clk);
            if (c == raise0_at) req[0] = 1'b1;
            chk({nm, " grant"}, 32'(grant), 32'(g));
            chk({nm, " busy"},  32'(busy),  32'd1);
            if (mem_en) begin
                chk({nm, " issue<8"},  32'(iss < 8), 32'd1);
                chk({nm, " mem_addr"}, 32'(mem_addr), 32'(base + 16'(2 * iss)));
                iss++;
            end
            if (fill_we) begin
                chk({nm, " fill_idx"},  32'(fill_idx),  32'(wr));
                chk({nm, " fill_data"}, 32'(fill_data), 32'((base + 16'(2 * wr)) ^ 16'hA5A5));
                wr++;
            end
            if (fill_done != 2'b00) begin
                chk({nm, " fill_done"},  32'(fill_done), 32'(g));
                chk({nm, " tag_we"},     32'(tag_we),    32'd1);
                chk({nm, " word count"}, 32'(wr),        32'd8);
                chk({nm, " issue cnt"},  32'(iss),       32'd8);
                chk({nm, " done cycle"}, 32'(c),         32'(done_at));
                done = 1'b1;
            end else begin
                chk({nm, " tag_we idle"}, 32'(tag_we), 32'd0);
            end
        end
        if (!done) chk({nm, " timeout"}, 32'd0, 32'd1);
    endtask

    initial begin
        rst = 1'b1; req = 2'b00; req_addr = '0; stray = 1'b0; lat = 4;
        repeat (2) @(negedge clk);
        all_zero_chk("reset");
        rst = 1'b0;
        @(negedge clk);

        // Single D-cache miss
        req_addr[15:0] = 16'h1236; req = 2'b01;
        run_fill("t1", 2'b01, 16'h1230, 12, 0);
        req = 2'b00;
        @(negedge clk);
        idle_chk("t1 end");

        // Simultaneous requests: D first, one idle cycle, then I
        req_addr = {16'h8000, 16'h0040}; req = 2'b11;
        run_fill("t2d", 2'b01, 16'h0040, 12, 0);
        req = 2'b10;
        @(negedge clk);
        idle_chk("t2 gap");
        run_fill("t2i", 2'b10, 16'h8000, 12, 0);
        req = 2'b00;
        @(negedge clk);
        idle_chk("t2 end");

        // Higher priority arrives mid-fill and must wait
        req_addr = {16'h4422, 16'h0040}; req = 2'b10;
        run_fill("t3i", 2'b10, 16'h4420, 12, 3);
        req = 2'b01;
        @(negedge clk);
        idle_chk("t3 gap");
        run_fill("t3d", 2'b01, 16'h0040, 12, 0);
        req = 2'b00;
        @(negedge clk);

        // Top line with latency 1 and 7
        repeat (8) @(negedge clk);
        lat = 1;
        req_addr[15:0] = 16'hFFFE; req = 2'b01;
        run_fill("t4 L1", 2'b01, 16'hFFF0, 9, 0);
        req = 2'b00;
        repeat (8) @(negedge clk);
        lat = 7;
        req = 2'b01;
        run_fill("t4 L7", 2'b01, 16'hFFF0, 15, 0);
        req = 2'b00;
        repeat (8) @(negedge clk);
        lat = 4;

        // Reset in cycle 6 of a fill
        req_addr[15:0] = 16'h2468; req = 2'b01;
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        all_zero_chk("t5 rst");
        rst = 1'b0;
        req_addr[15:0] = 16'h1112;
        run_fill("t5", 2'b01, 16'h1110, 12, 0);
        req = 2'b00;
        @(negedge clk);

        // Stray valid while idle
        stray = 1'b1;
        #1;
        chk("t6 stray fill_we",   32'(fill_we),   32'd0);
        chk("t6 stray tag_we",    32'(tag_we),    32'd0);
        chk("t6 stray fill_done", 32'(fill_done), 32'd0);
        @(negedge clk);
        stray = 1'b0;
        req_addr[15:0] = 16'h3000; req = 2'b01;
        run_fill("t6", 2'b01, 16'h3000, 12, 0);
        req = 2'b00;
        @(negedge clk);
        idle_chk("t6 end");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
